// File: rtl/mux_rr_sel_ctrl.sv
// Round-robin owner selection for a shared 16:1 one-bit mux.
// The owner keeps the mux until it releases, drops its request, or the hold limit runs out.
module mux_rr_sel_ctrl #(
  parameter int N        = 16,
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             release_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [N-1:0]     gnt_o,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic [N-1:0]       upper_req;
  logic [SEL_W-1:0]   winner;
  logic               end_rel;
  logic               end_drop;
  logic               end_hold;
  logic               grant_end;

  // Requests at or above the round-robin pointer win over the wrapped-around ones.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_upper
      assign upper_req[gi] = req_i[gi] & (SEL_W'(gi) >= ptr_q);
    end
  endgenerate

  function automatic logic [SEL_W-1:0] lowest_set(input logic [N-1:0] vec);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  assign winner    = (|upper_req) ? lowest_set(upper_req) : lowest_set(req_i);
  assign end_rel   = release_i;
  assign end_drop  = ~req_i[sel_q];
  assign end_hold  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign grant_end = end_rel | end_drop | end_hold;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          sel_d      = winner;
          gnt_d      = N'(1) << winner;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (grant_end) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = sel_q + SEL_W'(1);
          timeout_d = end_hold & ~end_rel & ~end_drop;
          state_d   = ST_IDLE;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_LAST)) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign sel_o     = sel_q;
  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule
